// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU core widths, stack sizing and stack overflow-policy encoding.
package cpu_pkg;
  localparam int PC_W        = 12;
  localparam int STACK_DEPTH = 3;
  localparam bit MODE_SAT    = 1'b0;
  localparam bit MODE_WRAP   = 1'b1;
endpackage

// File: rtl/call_stack.sv
// call_stack: parametrised return-address stack with wrap/saturate overflow policy and sticky error flags.
module call_stack
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = PC_W,
  parameter int DEPTH     = STACK_DEPTH,
  parameter bit WRAP_MODE = MODE_WRAP,
  localparam int SP_W     = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] pushAddr,
  input  logic              clearErr,
  output logic [ADDR_W-1:0] topAddr,
  output logic [SP_W-1:0]   sp,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);
  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("call_stack: DEPTH must be in 2..16");
  end
  function automatic logic [SP_W-1:0] inc(input logic [SP_W-1:0] p);
    return (p == SP_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  function automatic logic [SP_W-1:0] dec(input logic [SP_W-1:0] p);
    return (p == '0) ? SP_W'(DEPTH - 1) : p - 1'b1;
  endfunction
  logic [ADDR_W-1:0] entries_q [DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, top_idx, wr_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              is_empty, is_full, do_rep, do_push, do_pop, wr_en;
  assign is_empty = cnt_q == '0;
  assign is_full  = cnt_q == CNT_W'(DEPTH);
  assign top_idx  = dec(sp_q);
  // push+pop on an empty stack degrades to a plain push, so it never underflows
  always_comb begin
    do_rep  = push && pop && !is_empty;
    do_push = push && !do_rep;
    do_pop  = pop && !push;
    wr_en   = do_rep || (do_push && (!is_full || WRAP_MODE));
    wr_idx  = do_rep ? top_idx : sp_q;
    sp_d    = (do_push && (!is_full || WRAP_MODE)) ? inc(sp_q) :
              (do_pop && (!is_empty || WRAP_MODE)) ? top_idx : sp_q;
    cnt_d   = (do_push && !is_full) ? cnt_q + 1'b1 :
              (do_pop && !is_empty) ? cnt_q - 1'b1 : cnt_q;
    ovf_d   = (do_push && is_full) || (ovf_q && !clearErr);
    unf_d   = (do_pop && is_empty) || (unf_q && !clearErr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr_en) entries_q[wr_idx] <= pushAddr;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign topAddr   = (is_empty && !WRAP_MODE) ? '0 : entries_q[top_idx];
  assign sp        = sp_q;
  assign count     = cnt_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
endmodule

// File: doc/call_stack.md
# call_stack

Parametrised subroutine return-address stack for the 4-bit CPU core. It replaces the unconnected fixed stack stub and is driven by the decoder on JMS (push) and BBL (pop). `topAddr` feeds the PC reload mux. It adds configurable depth and width, a selectable wrap or saturate overflow policy, simultaneous push+pop (replace-top), and sticky error flags with clear.

## Interface
- `ADDR_W`, default 12, width of a stored return address.
- `DEPTH`, default 3, number of entries, legal range 2..16.
- `WRAP_MODE`, default 1.
  - 1: circular, 4004-compatible. Overflow overwrites the oldest entry; underflow rotates the pointer.
  - 0: saturating. Overflowing or underflowing operations are dropped.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `push` input 1: store `pushAddr` as the new top this cycle.
- `pop` input 1: discard the current top this cycle.
- `pushAddr` input ADDR_W: return address to store, normally PC+2 from the PC block.
- `clearErr` input 1: clears `overflow` and `underflow`.
- `topAddr` output ADDR_W: current top entry, combinational from registered state.
- `sp` output clog2(DEPTH): index of the next free slot.
- `count` output clog2(DEPTH+1): number of valid entries, 0..DEPTH.
- `empty` output 1: high when `count` == 0.
- `full` output 1: high when `count` == DEPTH.
- `overflow` output 1: sticky; set by a push while full.
- `underflow` output 1: sticky; set by a pop while empty.

## Operation
- Storage is DEPTH × ADDR_W registers indexed by `sp`. The top is `entries[(sp-1) mod DEPTH]`. All pointer arithmetic is modulo DEPTH and must be correct for DEPTH values that are not a power of two.
- **Push, not full:** `entries[sp]` ← `pushAddr`; `sp` ← `sp`+1; `count` ← `count`+1.
- **Push while full, WRAP_MODE=1:** overwrite `entries[sp]`, which holds the oldest entry; `sp` ← `sp`+1; `count` stays DEPTH; set `overflow`.
- **Push while full, WRAP_MODE=0:** no storage or pointer change; set `overflow`.
- **Pop, not empty:** `sp` ← `sp`-1; `count` ← `count`-1. Entry contents are not cleared.
- **Pop while empty, WRAP_MODE=1:** `sp` ← `sp`-1; `count` stays 0; set `underflow`. Stale contents become visible at `topAddr`.
- **Pop while empty, WRAP_MODE=0:** no change; set `underflow`.
- **Push and pop in the same cycle, not empty:** replace the top. `entries[sp-1]` ← `pushAddr`; `sp` and `count` do not change; no flag is set.
- **Push and pop in the same cycle, while empty:** behaves as a plain push. `count` becomes 1 and `underflow` is not set.
- **`topAddr` value:**
  - While empty in WRAP_MODE=0, `topAddr` is 0.
  - Otherwise, including while empty in WRAP_MODE=1, `topAddr` = `entries[(sp-1) mod DEPTH]`.
- **Error flags:**
  - `overflow` and `underflow` stay set until `clearErr` or `rst`.
  - If `clearErr` arrives in the same cycle as a new error event, the set wins.

## Timing
- All state updates on the rising edge of `clk`. No multicycle paths.
- **Latency:**
  - `topAddr`, `count`, `empty` and `full` reflect an operation one cycle after the edge that samples it.
  - During the cycle in which `pop` is asserted, `topAddr` still shows the entry being popped. The PC samples it in that same cycle.
- The decoder asserts `push` or `pop` for exactly one clock per instruction. The block tolerates back-to-back operations on every cycle.
- **Reset:**
  - `rst` overrides every other input.
  - On reset: all entries ← 0, `sp` ← 0, `count` ← 0, `empty` ← 1, `full` ← 0, `overflow` ← 0, `underflow` ← 0, `topAddr` ← 0.
  - Reset asserted in the middle of a push/pop sequence discards all state on the next edge. No partial write is kept.

## Structure
- The shared package `cpu_pkg` holds:
  - `PC_W` = 12, the default for `ADDR_W`.
  - `STACK_DEPTH` = 3.
  - Localparams for the wrap/saturate mode encoding.
- This is a single module with no sub-module. The modulo-DEPTH increment/decrement is local functions.
- `sp` and `count` widths are derived with `$clog2`. Elaboration fails on DEPTH < 2 or DEPTH > 16.

## Test plan
All scenarios use ADDR_W=12 and DEPTH=3.
1. **Reset then fill:** reset, then push 0x123, 0x456, 0x789 → `count`=3, `full`=1, `topAddr`=0x789; three pops return 0x789, 0x456, 0x123, then `empty`=1.
2. **Overflow, WRAP_MODE=1:** push 0x001..0x004 → `overflow`=1, `count`=3; pops return 0x004, 0x003, 0x002.
3. **Overflow, WRAP_MODE=0:** the same four pushes → pops return 0x003, 0x002, 0x001; `overflow`=1; `clearErr` → `overflow`=0.
4. **Replace-top:** push 0x0AA, then push+pop with 0x0BB → `count`=1, `topAddr`=0x0BB; push+pop while empty with 0x0CC → `count`=1, `underflow`=0.
5. **Underflow:** pop while empty → `underflow`=1.
   - WRAP_MODE=0: `sp` unchanged, `topAddr`=0.
   - WRAP_MODE=1: `sp` goes 0→2.
   - A `clearErr` in the same cycle as the erroring pop leaves `underflow`=1.
6. **Mid-sequence reset:** push 0x111 and 0x222, then assert `rst` for one cycle together with a push → all outputs return to reset values; the pushed value is not stored.
